// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address-field helpers for the
// 2-way write-through data cache.
package cache_pkg;

  localparam int ADDR_W    = 32;
  localparam int INDEX_W   = 6;
  localparam int TAG_W     = 10;
  localparam int LINE_W    = 64;
  localparam int WORD_W    = 32;
  localparam int WORD_BIT  = 2;
  localparam int INDEX_LSB = 3;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_W;
  localparam int SETS      = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] a);
    return a[INDEX_LSB +: INDEX_W];
  endfunction

  function automatic logic word_of(input logic [ADDR_W-1:0] a);
    return a[WORD_BIT];
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// MEM-stage request bus and SRAM-controller bus used by cache_controller.
interface cache_mem_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;

  modport master (output address, wdata, MEM_R_EN, MEM_W_EN, input rdata, ready);
  modport slave  (input address, wdata, MEM_R_EN, MEM_W_EN, output rdata, ready);
endinterface

interface cache_sram_if;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport master (output sram_address, sram_wdata, sram_rd_en, sram_wr_en,
                  input sram_rdata, sram_ready);
  modport slave  (input sram_address, sram_wdata, sram_rd_en, sram_wr_en,
                  output sram_rdata, sram_ready);
endinterface

// File: rtl/cache_storage.sv
// Valid/tag/data/lru arrays: combinational lookup by index, clocked fill and
// word update; valid and lru bits clear on reset.
module cache_storage
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] i_index,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic               i_word,
  output logic               o_hit,
  output logic               o_hit_way,
  output logic               o_valid0,
  output logic               o_valid1,
  output logic               o_lru,
  output logic [WORD_W-1:0]  o_rdata,
  input  logic               i_fill_en,
  input  logic               i_fill_way,
  input  logic [LINE_W-1:0]  i_fill_data,
  input  logic               i_wr_en,
  input  logic               i_wr_way,
  input  logic [WORD_W-1:0]  i_wr_data,
  input  logic               i_lru_en,
  input  logic               i_lru_val
);

  logic [SETS-1:0]   r_valid0;
  logic [SETS-1:0]   r_valid1;
  logic [SETS-1:0]   r_lru;
  logic [TAG_W-1:0]  r_tag0  [SETS];
  logic [TAG_W-1:0]  r_tag1  [SETS];
  logic [LINE_W-1:0] r_data0 [SETS];
  logic [LINE_W-1:0] r_data1 [SETS];

  logic              w_hit0;
  logic              w_hit1;
  logic [LINE_W-1:0] w_line;

  assign w_hit0    = r_valid0[i_index] && (r_tag0[i_index] == i_tag);
  assign w_hit1    = r_valid1[i_index] && (r_tag1[i_index] == i_tag);
  assign o_hit     = w_hit0 | w_hit1;
  assign o_hit_way = w_hit1;
  assign o_valid0  = r_valid0[i_index];
  assign o_valid1  = r_valid1[i_index];
  assign o_lru     = r_lru[i_index];
  assign w_line    = w_hit1 ? r_data1[i_index] : r_data0[i_index];
  assign o_rdata   = i_word ? w_line[63:32] : w_line[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      if (i_fill_en) begin
        if (i_fill_way) r_valid1[i_index] <= 1'b1;
        else            r_valid0[i_index] <= 1'b1;
      end
      if (i_lru_en) r_lru[i_index] <= i_lru_val;
    end
  end

  // Tags and data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      if (i_fill_way) begin
        r_tag1[i_index]  <= i_tag;
        r_data1[i_index] <= i_fill_data;
      end else begin
        r_tag0[i_index]  <= i_tag;
        r_data0[i_index] <= i_fill_data;
      end
    end else if (i_wr_en) begin
      if (i_wr_way) begin
        if (i_word) r_data1[i_index][63:32] <= i_wr_data;
        else        r_data1[i_index][31:0]  <= i_wr_data;
      end else begin
        if (i_word) r_data0[i_index][63:32] <= i_wr_data;
        else        r_data0[i_index][31:0]  <= i_wr_data;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller.
module cache_controller
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cache_mem_if.slave   mem_bus,
  cache_sram_if.master sram_bus
);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_READ_MISS = READ_MISS;
  localparam logic [1:0] ST_WRITE     = WRITE;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic               w_word;
  logic               w_hit;
  logic               w_hit_way;
  logic               w_valid0;
  logic               w_valid1;
  logic               w_lru;
  logic               w_victim;
  logic [WORD_W-1:0]  w_cache_word;
  logic [WORD_W-1:0]  w_bypass_word;
  logic               w_wr_active;
  logic               w_rd_active;
  logic               w_fill_en;
  logic               w_wr_en;
  logic               w_lru_en;
  logic               w_lru_val;
  logic               w_unused;

  assign w_tag    = tag_of(mem_bus.address);
  assign w_index  = index_of(mem_bus.address);
  assign w_word   = word_of(mem_bus.address);
  assign w_unused = ^{mem_bus.address[1:0], mem_bus.address[31:19]};

  assign w_victim      = !w_valid0 ? 1'b0 : (!w_valid1 ? 1'b1 : w_lru);
  assign w_bypass_word = w_word ? sram_bus.sram_rdata[63:32] : sram_bus.sram_rdata[31:0];

  // A write wins over a simultaneous read; the request itself is never latched
  // because the MEM stage holds it stable while ready is low.
  assign w_wr_active = (r_state == ST_WRITE) ||
                       ((r_state == ST_IDLE) && mem_bus.MEM_W_EN);
  assign w_rd_active = (r_state == ST_READ_MISS) ||
                       ((r_state == ST_IDLE) && mem_bus.MEM_R_EN &&
                        !mem_bus.MEM_W_EN && !w_hit);

  cache_storage u_storage (
    .clk         (clk),
    .rst         (rst),
    .i_index     (w_index),
    .i_tag       (w_tag),
    .i_word      (w_word),
    .o_hit       (w_hit),
    .o_hit_way   (w_hit_way),
    .o_valid0    (w_valid0),
    .o_valid1    (w_valid1),
    .o_lru       (w_lru),
    .o_rdata     (w_cache_word),
    .i_fill_en   (w_fill_en),
    .i_fill_way  (w_victim),
    .i_fill_data (sram_bus.sram_rdata),
    .i_wr_en     (w_wr_en),
    .i_wr_way    (w_hit_way),
    .i_wr_data   (mem_bus.wdata),
    .i_lru_en    (w_lru_en),
    .i_lru_val   (w_lru_val)
  );

  always_comb begin
    w_next                = r_state;
    mem_bus.ready         = 1'b1;
    mem_bus.rdata         = '0;
    sram_bus.sram_address = '0;
    sram_bus.sram_wdata   = '0;
    sram_bus.sram_rd_en   = 1'b0;
    sram_bus.sram_wr_en   = 1'b0;
    w_fill_en             = 1'b0;
    w_wr_en               = 1'b0;
    w_lru_en              = 1'b0;
    w_lru_val             = 1'b0;
    // Outputs are held quiet while reset is asserted so an in-flight access
    // is dropped at once rather than on the next edge.
    if (!rst) begin
      if (w_wr_active) begin
        sram_bus.sram_wr_en   = 1'b1;
        sram_bus.sram_address = mem_bus.address;
        sram_bus.sram_wdata   = mem_bus.wdata;
        mem_bus.ready         = sram_bus.sram_ready;
        if (sram_bus.sram_ready) begin
          w_wr_en   = w_hit;
          w_lru_en  = w_hit;
          w_lru_val = ~w_hit_way;
          w_next    = ST_IDLE;
        end else begin
          w_next    = ST_WRITE;
        end
      end else if (w_rd_active) begin
        sram_bus.sram_rd_en   = 1'b1;
        sram_bus.sram_address = {mem_bus.address[31:3], 3'b000};
        mem_bus.ready         = sram_bus.sram_ready;
        if (sram_bus.sram_ready) begin
          mem_bus.rdata = w_bypass_word;
          w_fill_en     = 1'b1;
          w_lru_en      = 1'b1;
          w_lru_val     = ~w_victim;
          w_next        = ST_IDLE;
        end else begin
          w_next        = ST_READ_MISS;
        end
      end else if ((r_state == ST_IDLE) && mem_bus.MEM_R_EN) begin
        mem_bus.rdata = w_cache_word;
        w_lru_en      = 1'b1;
        w_lru_val     = ~w_hit_way;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed and randomized bench for cache_controller against a recency-list
// cache model and a word-addressed backing memory.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_mem_if  mem_bus();
  cache_sram_if sram_bus();

  cache_controller dut (
    .clk      (clk),
    .rst      (rst),
    .mem_bus  (mem_bus),
    .sram_bus (sram_bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [31:0] mem_model [int unsigned];
  // Per set: tags currently cached, most recently used first, at most two.
  logic [9:0]  set_q [64][$];

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k;
    k = {15'd0, a[18:2]};
    if (mem_model.exists(k)) return mem_model[k];
    return (k * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int find(input logic [31:0] a);
    int s;
    s = int'(a[8:3]);
    for (int i = 0; i < set_q[s].size(); i++)
      if (set_q[s][i] == a[18:9]) return i;
    return -1;
  endfunction

  function automatic void touch(input logic [31:0] a);
    int s;
    int p;
    s = int'(a[8:3]);
    p = find(a);
    if (p >= 0) set_q[s].delete(p);
    set_q[s].push_front(a[18:9]);
    if (set_q[s].size() > 2) void'(set_q[s].pop_back());
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) set_q[s].delete();
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string nm);
    #1;
    chk({nm, ".rd_en_after"}, 64'(sram_bus.sram_rd_en), 64'(1'b0));
    chk({nm, ".wr_en_after"}, 64'(sram_bus.sram_wr_en), 64'(1'b0));
  endtask

  task automatic do_read(input logic [31:0] a, input int lat, input string nm);
    logic        exp_hit;
    logic [31:0] exp;
    logic [31:0] line;
    exp_hit = (find(a) >= 0);
    exp     = mem_rd(a);
    line    = {a[31:3], 3'b000};
    mem_bus.address  = a;
    mem_bus.MEM_W_EN = 1'b0;
    mem_bus.MEM_R_EN = 1'b1;
    #1;
    if (exp_hit) begin
      chk({nm, ".hit_ready"}, 64'(mem_bus.ready), 64'(1'b1));
      chk({nm, ".hit_rd_en"}, 64'(sram_bus.sram_rd_en), 64'(1'b0));
      chk({nm, ".hit_rdata"}, 64'(mem_bus.rdata), 64'(exp));
    end else begin
      chk({nm, ".miss_ready"}, 64'(mem_bus.ready), 64'(1'b0));
      chk({nm, ".miss_rd_en"}, 64'(sram_bus.sram_rd_en), 64'(1'b1));
      chk({nm, ".miss_wr_en"}, 64'(sram_bus.sram_wr_en), 64'(1'b0));
      chk({nm, ".miss_addr"}, 64'(sram_bus.sram_address), 64'(line));
      for (int i = 0; i < lat; i++) cycle();
      if (lat > 0) begin
        #1;
        chk({nm, ".wait_ready"}, 64'(mem_bus.ready), 64'(1'b0));
        chk({nm, ".wait_rd_en"}, 64'(sram_bus.sram_rd_en), 64'(1'b1));
      end
      sram_bus.sram_rdata = {mem_rd(line + 32'd4), mem_rd(line)};
      sram_bus.sram_ready = 1'b1;
      #1;
      chk({nm, ".fill_ready"}, 64'(mem_bus.ready), 64'(1'b1));
      chk({nm, ".fill_rdata"}, 64'(mem_bus.rdata), 64'(exp));
    end
    cycle();
    mem_bus.MEM_R_EN    = 1'b0;
    sram_bus.sram_ready = 1'b0;
    touch(a);
    check_quiet(nm);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat,
                          input logic both, input string nm);
    mem_bus.address  = a;
    mem_bus.wdata    = d;
    mem_bus.MEM_W_EN = 1'b1;
    mem_bus.MEM_R_EN = both;
    #1;
    chk({nm, ".wr_ready"}, 64'(mem_bus.ready), 64'(1'b0));
    chk({nm, ".wr_en"}, 64'(sram_bus.sram_wr_en), 64'(1'b1));
    chk({nm, ".wr_rd_en"}, 64'(sram_bus.sram_rd_en), 64'(1'b0));
    chk({nm, ".wr_addr"}, 64'(sram_bus.sram_address), 64'(a));
    chk({nm, ".wr_data"}, 64'(sram_bus.sram_wdata), 64'(d));
    for (int i = 0; i < lat; i++) cycle();
    if (lat > 0) begin
      #1;
      chk({nm, ".wr_wait_ready"}, 64'(mem_bus.ready), 64'(1'b0));
      chk({nm, ".wr_wait_en"}, 64'(sram_bus.sram_wr_en), 64'(1'b1));
    end
    sram_bus.sram_ready = 1'b1;
    #1;
    chk({nm, ".wr_done_ready"}, 64'(mem_bus.ready), 64'(1'b1));
    cycle();
    mem_bus.MEM_W_EN    = 1'b0;
    mem_bus.MEM_R_EN    = 1'b0;
    sram_bus.sram_ready = 1'b0;
    mem_model[{15'd0, a[18:2]}] = d;
    if (find(a) >= 0) touch(a);
    check_quiet(nm);
  endtask

  initial begin
    logic [31:0] ra;
    rst                   = 1'b1;
    mem_bus.address       = '0;
    mem_bus.wdata         = '0;
    mem_bus.MEM_R_EN      = 1'b0;
    mem_bus.MEM_W_EN      = 1'b0;
    sram_bus.sram_rdata   = '0;
    sram_bus.sram_ready   = 1'b0;
    model_reset();
    #1;
    chk("rst.ready", 64'(mem_bus.ready), 64'(1'b1));
    chk("rst.rd_en", 64'(sram_bus.sram_rd_en), 64'(1'b0));
    chk("rst.wr_en", 64'(sram_bus.sram_wr_en), 64'(1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.ready", 64'(mem_bus.ready), 64'(1'b1));
    chk("post_rst.rdata", 64'(mem_bus.rdata), 64'(32'h0));

    // Fill 0x10 with a 5-cycle SRAM latency, then hit the other half.
    mem_model[32'h10 >> 2] = 32'h1111_1111;
    mem_model[32'h14 >> 2] = 32'h2222_2222;
    do_read(32'h10, 5, "t1_miss");
    do_read(32'h14, 0, "t1_hit");

    // Stray sram_ready with no request must change nothing.
    sram_bus.sram_ready = 1'b1;
    #1;
    chk("stray.ready", 64'(mem_bus.ready), 64'(1'b1));
    cycle();
    sram_bus.sram_ready = 1'b0;
    do_read(32'h14, 0, "stray_hit");

    // Write-through hit updates the cached word only.
    do_write(32'h14, 32'hDEAD_BEEF, 3, 1'b0, "wr_hit");
    do_read(32'h14, 0, "wr_hit_rd14");
    do_read(32'h10, 0, "wr_hit_rd10");

    // Write miss does not allocate.
    do_write(32'h800, 32'hCAFE_0800, 2, 1'b0, "wr_miss");
    do_read(32'h800, 1, "wr_miss_rd");

    // LRU replacement in set 2.
    do_read(32'h210, 2, "lru_a");
    do_read(32'h410, 0, "lru_b");
    do_read(32'h210, 0, "lru_hit_a");
    do_read(32'h610, 1, "lru_c");
    do_read(32'h210, 0, "lru_keep_a");
    do_read(32'h410, 1, "lru_evicted_b");

    // Read and write together: only the write is serviced.
    do_write(32'h20, 32'h1234_5678, 1, 1'b1, "both");
    do_read(32'h20, 0, "both_rd");

    // Reset in the middle of a miss.
    mem_bus.address  = 32'h1010;
    mem_bus.MEM_R_EN = 1'b1;
    #1;
    chk("rst_mid.rd_en0", 64'(sram_bus.sram_rd_en), 64'(1'b1));
    cycle();
    #1;
    chk("rst_mid.rd_en1", 64'(sram_bus.sram_rd_en), 64'(1'b1));
    rst = 1'b1;
    #1;
    chk("rst_mid.rd_en", 64'(sram_bus.sram_rd_en), 64'(1'b0));
    chk("rst_mid.ready", 64'(mem_bus.ready), 64'(1'b1));
    mem_bus.MEM_R_EN = 1'b0;
    model_reset();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_mid.post_ready", 64'(mem_bus.ready), 64'(1'b1));
    do_read(32'h10, 2, "rst_mid_reread");

    // Random mix over a few conflicting sets.
    for (int n = 0; n < 300; n++) begin
      ra = {13'd0, 10'($urandom_range(0, 3)), 6'($urandom_range(2, 3)),
            1'($urandom), 2'($urandom)};
      if ($urandom_range(0, 99) < 35)
        do_write(ra, $urandom, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) == 0), "rnd_wr");
      else
        do_read(ra, int'($urandom_range(0, 3)), "rnd_rd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache controller between the MEM stage and the 16-bit SRAM controller.
- Read hits complete in the same cycle without touching SRAM.
- Read misses fetch a 64-bit line (two words) from SRAM.
- Writes always go to SRAM; they also update the cached word on a hit.
- The pipeline freezes on ready=0.

Parameters:
- ADDR_W, 32, width of MEM-stage address (byte address, already mapped to base 0)
- INDEX_W, 6, set index bits (64 sets)
- TAG_W, 10, tag bits (address[18:9])

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- address  in  32  byte address from MEM stage
- wdata  in  32  store data
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- rdata  out  32  load result
- ready  out  1  1 = request complete or no request; 0 = freeze pipeline
- sram_address  out  32  address to SRAM controller (line-aligned for reads)
- sram_wdata  out  32  store data to SRAM controller
- sram_rd_en  out  1  line read request
- sram_wr_en  out  1  word write request
- sram_rdata  in  64  line from SRAM: [31:0] = word at line address, [63:32] = word at line address+4
- sram_ready  in  1  one-cycle pulse: SRAM operation complete

Behaviour:
- Address split:
  - [1:0] ignored.
  - [2] selects the word in the line.
  - [8:3] is the index.
  - [18:9] is the tag.
  - [31:19] ignored.
- Per set: valid0/1, tag0/1, data0/1 (64-bit), one lru bit. lru=0 means way0 is least recently used.
- hit = (valid0 & tag0==tag) | (valid1 & tag1==tag). Both ways matching cannot occur by construction.
- FSM states: IDLE, READ_MISS, WRITE.
- IDLE:
  - No request: ready=1, sram_rd_en=0, sram_wr_en=0, rdata=0.
  - MEM_R_EN & hit: ready=1 combinationally. rdata = selected word of the hit way. At the clock edge, lru <= ~hit_way.
  - MEM_R_EN & miss: ready=0, sram_rd_en=1, sram_address={address[31:3],3'b000}. If sram_ready is already 1 this cycle, complete as in READ_MISS; else go to READ_MISS.
  - MEM_W_EN (any hit/miss): ready=0, sram_wr_en=1, sram_address=address, sram_wdata=wdata. If sram_ready is already 1, complete as in WRITE; else go to WRITE.
  - MEM_R_EN & MEM_W_EN together is illegal; the write is serviced, the read is ignored.
- READ_MISS:
  - Hold sram_rd_en=1 and address; ready=0.
  - On sram_ready=1, choose the victim: way0 if !valid0, else way1 if !valid1, else the lru way.
  - Write tag, valid=1, data=sram_rdata into the victim; lru <= ~victim.
  - Same cycle: ready=1 and rdata = selected word of sram_rdata (bypass, not the array). Next state IDLE.
- WRITE:
  - Hold sram_wr_en=1 and sram_wdata; ready=0.
  - On sram_ready=1: if hit, overwrite the addressed 32-bit half of the hit way's line and set lru <= ~hit_way. A miss allocates nothing.
  - Same cycle ready=1; next state IDLE.
- The MEM stage holds address, wdata and the enables stable while ready=0. The controller does not register the request.
- After a completion the controller is in IDLE. The next request is evaluated in the following cycle, and a back-to-back miss restarts SRAM access immediately.
- sram_rd_en and sram_wr_en are never both 1.
- Both enables are 0 in the cycle after an sram_ready completion unless a new miss or write is presented in IDLE.
- Reset (async, any state, including mid-miss): state=IDLE, all valid=0, all lru=0. Tags and data are don't-care. ready=1 once rst deasserts with no request. The SRAM controller shares rst, so an in-flight access is dropped.
- An sram_ready pulse seen in IDLE with no request is ignored.

Decomposition:
- Shared package cache_pkg:
  - INDEX_W, TAG_W, line width 64, word-select bit position.
  - State enum {IDLE, READ_MISS, WRITE}.
  - Address-field helper functions (tag_of, index_of, word_of).
- Sub-module cache_storage:
  - Holds the valid/tag/data/lru arrays; async read by index, sync write with async reset of valid and lru.
  - Exposes hit, hit_way, per-way valid, and a read word.
- cache_controller contains the FSM and output muxing.

Test Plan:
- Reset, then MEM_R_EN at 0x0000_0010 -> ready=0, sram_rd_en=1, sram_address=0x10. SRAM returns 0x2222_2222_1111_1111 after 5 cycles -> ready=1 and rdata=0x1111_1111 in that cycle; following read of 0x14 -> ready=1 same cycle, rdata=0x2222_2222, no SRAM access.
- Fill set 2 with tags 0x001 (addr 0x210) and 0x002 (addr 0x410). Read 0x210 (hit, lru->way1), then miss at 0x610 -> victim is the way holding 0x410; later read 0x210 still hits, read 0x410 misses.
- Store 0xDEAD_BEEF to cached 0x14 -> sram_wr_en=1, sram_address=0x14, ready only on sram_ready; subsequent read of 0x14 hits with 0xDEAD_BEEF and 0x10 still returns 0x1111_1111.
- Store to uncached 0x800 -> SRAM write only; next read of 0x800 misses (no allocate).
- Assert rst mid READ_MISS -> sram_rd_en=0 immediately, ready=1; re-read of the previously filled 0x10 misses (valids cleared).
- MEM_R_EN and MEM_W_EN both high at 0x20 -> only sram_wr_en asserted; no fill occurs.
